// File: rtl/pwm_tone_decoder.sv
// pwm_tone_decoder: measures tone period/duration and rests on a PWM input.
// Define PWM_TONE_DECODER_GLITCH_FILTER_EN to enable the input glitch filter.
module pwm_tone_decoder #(
  parameter int CLK_FREQ       = 50000000,
  parameter int PERIOD_WIDTH   = 24,
  parameter int DURATION_WIDTH = 32,
  parameter int SILENCE_CYCLES = CLK_FREQ / 20,
  parameter int TOLERANCE      = 4,
  parameter int GLITCH_CYCLES  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pwm_in,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [PERIOD_WIDTH-1:0]   evt_period,
  output logic [DURATION_WIDTH-1:0] evt_duration,
  output logic                      evt_is_rest,
  output logic                      overflow
);

  localparam int PW = PERIOD_WIDTH;
  localparam int DW = DURATION_WIDTH;
  localparam logic [DW-1:0] SIL = DW'(SILENCE_CYCLES);
  localparam logic [PW-1:0] TOL = PW'(TOLERANCE);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    TONE
  } state_t;

  logic s1;
  logic s2;
  logic lvl;
  logic lvl_d;
  logic edge_pulse;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
    end
  end

`ifdef PWM_TONE_DECODER_GLITCH_FILTER_EN
  localparam int GCW = $clog2(GLITCH_CYCLES + 1);

  logic [GCW-1:0] gcnt;
  logic           filt;

  // level is taken only after GLITCH_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt <= 1'b0;
      gcnt <= '0;
    end else if (s2 == filt) begin
      gcnt <= '0;
    end else if (gcnt == GCW'(GLITCH_CYCLES - 1)) begin
      filt <= s2;
      gcnt <= '0;
    end else begin
      gcnt <= gcnt + GCW'(1);
    end
  end

  assign lvl = filt;
`else
  logic unused_glitch;

  assign unused_glitch = (GLITCH_CYCLES > 0);
  assign lvl = s2;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_d <= 1'b0;
    end else begin
      lvl_d <= lvl;
    end
  end

  assign edge_pulse = lvl & ~lvl_d;

  // gap = cycles since the last edge, so on an edge it equals the period
  logic [DW-1:0] gap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap <= '0;
    end else if (edge_pulse) begin
      gap <= DW'(1);
    end else if (~&gap) begin
      gap <= gap + DW'(1);
    end
  end

  logic [PW-1:0] meas;
  logic          timeout;

  assign meas    = gap[PW-1:0];
  assign timeout = (gap >= SIL);

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] ref_q;
  logic [PW-1:0] ref_d;
  logic [DW-1:0] dur_q;
  logic [DW-1:0] dur_d;
  logic          prior_q;
  logic          prior_d;

  logic [PW-1:0] dev;
  logic [DW:0]   sum;
  logic [DW-1:0] dur_sum;

  assign dev     = (meas >= ref_q) ? meas - ref_q : ref_q - meas;
  assign sum     = {1'b0, dur_q} + {1'b0, DW'(meas)};
  assign dur_sum = sum[DW] ? '1 : sum[DW-1:0];

  logic          emit;
  logic [PW-1:0] emit_period;
  logic [DW-1:0] emit_dur;
  logic          emit_rest;

  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    dur_d       = dur_q;
    prior_d     = prior_q;
    emit        = 1'b0;
    emit_period = '0;
    emit_dur    = '0;
    emit_rest   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (edge_pulse) begin
          state_d = ACQUIRE;
          if (prior_q && timeout) begin
            emit      = 1'b1;
            emit_dur  = gap;
            emit_rest = 1'b1;
          end
        end
      end
      ACQUIRE: begin
        if (edge_pulse) begin
          ref_d   = meas;
          dur_d   = DW'(meas);
          state_d = TONE;
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      TONE: begin
        if (edge_pulse) begin
          if (dev <= TOL) begin
            dur_d = dur_sum;
          end else begin
            emit        = 1'b1;
            emit_period = ref_q;
            emit_dur    = dur_q;
            ref_d       = meas;
            dur_d       = DW'(meas);
          end
        end else if (timeout) begin
          emit        = 1'b1;
          emit_period = ref_q;
          emit_dur    = dur_q;
          prior_d     = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ref_q   <= '0;
      dur_q   <= '0;
      prior_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      dur_q   <= dur_d;
      prior_q <= prior_d;
    end
  end

  // a new event while one is stalled is dropped and flagged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_valid    <= 1'b0;
      evt_period   <= '0;
      evt_duration <= '0;
      evt_is_rest  <= 1'b0;
      overflow     <= 1'b0;
    end else if (emit) begin
      if (!evt_valid || evt_ready) begin
        evt_valid    <= 1'b1;
        evt_period   <= emit_period;
        evt_duration <= emit_dur;
        evt_is_rest  <= emit_rest;
      end else begin
        overflow <= 1'b1;
      end
    end else if (evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule
